// File: rtl/posit_accum_sequencer_if.sv
// Stream, accumulator-core and result signals between the posit accumulator
// sequencer (master) and its environment: producers, core and consumer (slave).
interface posit_accum_sequencer_if #(
  parameter int NBITS = 32,
  parameter int CNT_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [NBITS-1:0] s_data;
  logic             s_last;
  logic [NBITS-1:0] acc_in;
  logic             acc_start;
  logic             acc_clear;
  logic [NBITS-1:0] acc_result;
  logic             acc_inf;
  logic             acc_zero;
  logic             acc_done;
  logic             m_valid;
  logic             m_ready;
  logic [NBITS-1:0] m_data;
  logic             m_inf;
  logic             m_zero;
  logic [CNT_W-1:0] m_count;

  modport master (
    input  s_valid, s_data, s_last, acc_result, acc_inf, acc_zero, acc_done, m_ready,
    output s_ready, acc_in, acc_start, acc_clear, m_valid, m_data, m_inf, m_zero, m_count
  );

  modport slave (
    output s_valid, s_data, s_last, acc_result, acc_inf, acc_zero, acc_done, m_ready,
    input  s_ready, acc_in, acc_start, acc_clear, m_valid, m_data, m_inf, m_zero, m_count
  );
endinterface

// File: rtl/posit_accum_sequencer.sv
// Feeds a batch of posit terms to the accumulator core, spaced to its feedback
// loop distance, and returns the batch sum on a valid/ready output.
//
// state  | meaning
// IDLE   | no batch in progress, ready for the first term
// GAP    | term issued, waiting out the core loop-back distance
// ACCEPT | spacing satisfied, ready for the next term
// DRAIN  | last term issued, waiting for its done
// OUT    | batch sum presented until the consumer takes it
module posit_accum_sequencer #(
  parameter int NBITS   = 32,
  parameter int ACC_LAT = 4,
  parameter int CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  posit_accum_sequencer_if.master        bus,
  output logic                           busy
);

  localparam int TW = $clog2(ACC_LAT) + 1;
  localparam logic [TW-1:0] TLOAD = TW'(ACC_LAT - 1);

  typedef enum logic [2:0] {IDLE, GAP, ACCEPT, DRAIN, OUT} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NBITS-1:0] acc_in_q, acc_in_d;
  logic             acc_start_q, acc_start_d;
  logic             acc_clear_q, acc_clear_d;
  logic [NBITS-1:0] m_data_q, m_data_d;
  logic             m_inf_q, m_inf_d;
  logic             m_zero_q, m_zero_d;
  logic [CNT_W-1:0] m_count_q, m_count_d;
  logic             s_ready_c;
  logic             accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      first_q     <= 1'b1;
      cnt_q       <= '0;
      acc_in_q    <= '0;
      acc_start_q <= 1'b0;
      acc_clear_q <= 1'b0;
      m_data_q    <= '0;
      m_inf_q     <= 1'b0;
      m_zero_q    <= 1'b0;
      m_count_q   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      first_q     <= first_d;
      cnt_q       <= cnt_d;
      acc_in_q    <= acc_in_d;
      acc_start_q <= acc_start_d;
      acc_clear_q <= acc_clear_d;
      m_data_q    <= m_data_d;
      m_inf_q     <= m_inf_d;
      m_zero_q    <= m_zero_d;
      m_count_q   <= m_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    first_d     = first_q;
    cnt_d       = cnt_q;
    acc_in_d    = acc_in_q;
    acc_start_d = 1'b0;
    acc_clear_d = 1'b0;
    m_data_d    = m_data_q;
    m_inf_d     = m_inf_q;
    m_zero_d    = m_zero_q;
    m_count_d   = m_count_q;
    s_ready_c   = 1'b0;

    case (state_q)
      IDLE:   s_ready_c = 1'b1;
      GAP: begin
        if (timer_q != '0) timer_d = timer_q - 1'b1;
        if (timer_q == TW'(1)) state_d = ACCEPT;
      end
      ACCEPT: s_ready_c = 1'b1;
      DRAIN: begin
        // done is masked while the timer runs: the previous term's done lands here
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (bus.acc_done) begin
          m_data_d  = bus.acc_result;
          m_inf_d   = bus.acc_inf;
          m_zero_d  = bus.acc_zero;
          m_count_d = cnt_q;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (bus.m_ready) begin
          first_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    accept = bus.s_valid & s_ready_c;
    if (accept) begin
      acc_in_d    = bus.s_data;
      acc_start_d = 1'b1;
      acc_clear_d = first_q;
      timer_d     = TLOAD;
      first_d     = 1'b0;
      cnt_d       = first_q ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
      state_d     = bus.s_last ? DRAIN : GAP;
    end
  end

  assign bus.s_ready   = s_ready_c;
  assign bus.acc_in    = acc_in_q;
  assign bus.acc_start = acc_start_q;
  assign bus.acc_clear = acc_clear_q;
  assign bus.m_valid   = (state_q == OUT);
  assign bus.m_data    = m_data_q;
  assign bus.m_inf     = m_inf_q;
  assign bus.m_zero    = m_zero_q;
  assign bus.m_count   = m_count_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_posit_accum_sequencer.sv
// Bench for posit_accum_sequencer: a behavioural accumulator core with exact
// half-unit arithmetic drives the core side; batch results are checked per step.
module tb_posit_accum_sequencer;
  localparam int NBITS   = 32;
  localparam int ACC_LAT = 4;
  localparam int CNT_W   = 8;
  localparam logic [31:0] NAR = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  logic core_done = 1'b0;
  logic stray_done = 1'b0;
  logic [31:0] core_result = '0;
  logic core_inf = 1'b0;
  logic core_zero = 1'b0;

  int checks = 0;
  int errors = 0;

  posit_accum_sequencer_if #(.NBITS(NBITS), .CNT_W(CNT_W)) ifc ();

  posit_accum_sequencer #(.NBITS(NBITS), .ACC_LAT(ACC_LAT), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  assign ifc.acc_done   = core_done | stray_done;
  assign ifc.acc_result = core_result;
  assign ifc.acc_inf    = core_inf;
  assign ifc.acc_zero   = core_zero;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // posit32, es=2, encoding of the exact value h/2
  function automatic logic [31:0] enc(input int h);
    logic [31:0] m, r;
    logic [63:0] bits;
    int p, sc, k, e, nb;
    if (h == 0) return 32'h0;
    m = (h < 0) ? 32'(-h) : 32'(h);
    p = 31;
    while (p > 0 && !m[p]) p--;
    sc = p - 1;
    k = (sc >= 0) ? sc / 4 : -((3 - sc) / 4);
    e = sc - 4 * k;
    bits = '0;
    nb = 0;
    if (k >= 0) begin
      for (int i = 0; i < k + 1; i++) begin bits = {bits[62:0], 1'b1}; nb++; end
      bits = {bits[62:0], 1'b0}; nb++;
    end else begin
      for (int i = 0; i < -k; i++) begin bits = {bits[62:0], 1'b0}; nb++; end
      bits = {bits[62:0], 1'b1}; nb++;
    end
    bits = {bits[61:0], 2'(e)}; nb += 2;
    for (int i = p - 1; i >= 0; i--) begin bits = {bits[62:0], m[i]}; nb++; end
    bits = bits << (31 - nb);
    r = bits[31:0];
    if (h < 0) r = ~r + 32'd1;
    return r;
  endfunction

  function automatic int dec(input logic [31:0] w);
    if (w == 32'h0) return 0;
    for (int n = -512; n <= 512; n++) if (enc(n) == w) return n;
    return 99999;
  endfunction

  // accumulator core model: exact running sum, result ACC_LAT cycles after start
  logic pv [3];
  int   ps [3];
  logic pinf [3];
  int   run = 0;
  logic run_inf = 1'b0;
  int   cyc = 0;
  int   last_start = -1;
  int   start_log[$];
  bit   clr_log[$];

  initial begin
    for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; ps[i] = 0; pinf[i] = 1'b0; end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) last_start = -1;
    if (ifc.acc_start) begin
      if (last_start >= 0) check("start_spacing", 64'(cyc - last_start >= ACC_LAT), 64'd1);
      last_start = cyc;
      start_log.push_back(cyc);
      clr_log.push_back(ifc.acc_clear);
      if (ifc.acc_clear) begin run = 0; run_inf = 1'b0; end
      if (ifc.acc_in == NAR) run_inf = 1'b1;
      else run += dec(ifc.acc_in);
    end
    pv[0] <= ifc.acc_start; ps[0] <= run; pinf[0] <= run_inf;
    for (int i = 1; i < 3; i++) begin pv[i] <= pv[i-1]; ps[i] <= ps[i-1]; pinf[i] <= pinf[i-1]; end
    core_done   <= pv[2];
    core_result <= pinf[2] ? NAR : enc(ps[2]);
    core_inf    <= pinf[2];
    core_zero   <= !pinf[2] && ps[2] == 0;
  end

  task automatic send(input logic [31:0] w, input logic l, input int maxgap);
    int  g;
    bit  ok;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    ok = 1'b0;
    repeat (g) begin @(posedge clk); #1; end
    ifc.s_valid = 1'b1; ifc.s_data = w; ifc.s_last = l;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (ifc.s_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    ifc.s_valid = 1'b0;
    ifc.s_data  = $urandom;
    ifc.s_last  = 1'($urandom_range(1, 0));
    check("accept", 64'(ok), 64'd1);
  endtask

  task automatic run_batch(input string tag, input logic [31:0] w[$], input int maxgap,
                           input int hold, input logic [31:0] exp_data,
                           input logic exp_zero, input logic exp_inf, input int exp_cnt);
    int n, nclr;
    start_log.delete();
    clr_log.delete();
    foreach (w[i]) send(w[i], 1'(i == w.size() - 1), maxgap);
    n = 0;
    while (!ifc.m_valid && n < 2000) begin @(posedge clk); #1; n++; end
    check({tag, "_valid"}, 64'(ifc.m_valid), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(ACC_LAT + 1));
    check({tag, "_data"}, 64'(ifc.m_data), 64'(exp_data));
    check({tag, "_zero"}, 64'(ifc.m_zero), 64'(exp_zero));
    check({tag, "_inf"}, 64'(ifc.m_inf), 64'(exp_inf));
    check({tag, "_count"}, 64'(ifc.m_count), 64'(exp_cnt));
    check({tag, "_starts"}, 64'(start_log.size()), 64'(w.size()));
    nclr = 0;
    foreach (clr_log[i]) nclr += int'(clr_log[i]);
    check({tag, "_clear_first"}, 64'(clr_log.size() > 0 && clr_log[0]), 64'd1);
    check({tag, "_clear_count"}, 64'(nclr), 64'd1);
    if (maxgap == 0)
      for (int i = 1; i < start_log.size(); i++)
        check({tag, "_exact_gap"}, 64'(start_log[i] - start_log[i-1]), 64'(ACC_LAT));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(ifc.m_valid), 64'd1);
      check({tag, "_hold_data"}, 64'(ifc.m_data), 64'(exp_data));
      check({tag, "_hold_count"}, 64'(ifc.m_count), 64'(exp_cnt));
      check({tag, "_hold_sready"}, 64'(ifc.s_ready), 64'd0);
    end
    ifc.m_ready = 1'b1;
    @(posedge clk); #1;
    ifc.m_ready = 1'b0;
    check({tag, "_release_valid"}, 64'(ifc.m_valid), 64'd0);
    check({tag, "_release_idle"}, 64'(busy), 64'd0);
    check({tag, "_release_sready"}, 64'(ifc.s_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] q[$];
    int tbl [4];
    int h, sum, nterms;
    tbl = '{1, 2, 4, -2};
    ifc.s_valid = 1'b0; ifc.s_data = '0; ifc.s_last = 1'b0; ifc.m_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_start", 64'(ifc.acc_start), 64'd0);
    check("rst_valid", 64'(ifc.m_valid), 64'd0);
    check("rst_data", 64'(ifc.m_data), 64'd0);
    check("rst_count", 64'(ifc.m_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_sready", 64'(ifc.s_ready), 64'd1);

    // m_ready with nothing pending has no effect
    ifc.m_ready = 1'b1;
    @(posedge clk); #1;
    ifc.m_ready = 1'b0;
    check("idle_mready", 64'(ifc.m_valid | busy), 64'd0);

    q = '{32'h4000_0000, 32'h4800_0000};
    run_batch("one_plus_two", q, 0, 0, 32'h4C00_0000, 1'b0, 1'b0, 2);
    q = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
    run_batch("four_ones", q, 3, 0, 32'h5000_0000, 1'b0, 1'b0, 4);
    q = '{32'h4000_0000, 32'hC000_0000};
    run_batch("cancel", q, 0, 0, 32'h0000_0000, 1'b1, 1'b0, 2);
    q = '{32'h3800_0000};
    run_batch("single_hold", q, 0, 10, 32'h3800_0000, 1'b0, 1'b0, 1);
    q = '{32'h4800_0000};
    run_batch("back_to_back", q, 0, 0, 32'h4800_0000, 1'b0, 1'b0, 1);
    q = '{NAR, 32'h4000_0000};
    run_batch("nar", q, 1, 0, NAR, 1'b0, 1'b1, 2);

    for (int b = 0; b < 3; b++) begin
      q.delete();
      sum = 0;
      nterms = int'($urandom_range(8, 2));
      for (int i = 0; i < nterms; i++) begin
        h = tbl[$urandom_range(3, 0)];
        sum += h;
        q.push_back(enc(h));
      end
      run_batch("random", q, 3, int'($urandom_range(3, 0)), enc(sum), 1'(sum == 0), 1'b0, nterms);
    end

    q.delete();
    for (int i = 0; i < 300; i++) q.push_back(32'h0);
    run_batch("saturate", q, 0, 0, 32'h0, 1'b1, 1'b0, 255);

    // reset while the second term's start strobe is high
    send(32'h4000_0000, 1'b0, 0);
    send(32'h4000_0000, 1'b0, 0);
    check("mid_gap_start", 64'(ifc.acc_start), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_start", 64'(ifc.acc_start), 64'd0);
    check("mid_rst_clear", 64'(ifc.acc_clear), 64'd0);
    check("mid_rst_in", 64'(ifc.acc_in), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_mcount", 64'(ifc.m_count), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("post_rst_sready", 64'(ifc.s_ready), 64'd1);
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("stray_done_valid", 64'(ifc.m_valid), 64'd0);
    check("stray_done_busy", 64'(busy), 64'd0);
    q = '{32'h4000_0000};
    run_batch("after_reset", q, 0, 0, 32'h4000_0000, 1'b0, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/posit_accum_sequencer.md
Name: posit_accum_sequencer

Overview:
- Initiator side of the posit accumulator core interface (in/start/clear → result/inf/zero/done).
- Accepts a batch of posit32 terms over a valid/ready stream, issues them to the accumulator core with the spacing its 4-stage feedback loop requires, then returns the packed batch sum on a valid/ready output.
- Sits between the PairHMM term producers and the posit accumulator core.

Parameters:
- NBITS, 32, posit word width.
- ACC_LAT, 4, accumulator core latency from start to done, equal to its loop-back distance.
- CNT_W, 8, width of the batch term counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input term valid.
- s_ready  out  1  sequencer can accept a term this cycle.
- s_data  in  NBITS  posit term.
- s_last  in  1  term is the last of its batch.
- acc_in  out  NBITS  term to the accumulator core (registered).
- acc_start  out  1  one-cycle issue strobe to the core (registered).
- acc_clear  out  1  with acc_start: core uses zero instead of feedback sum (first term of batch).
- acc_result  in  NBITS  core packed result.
- acc_inf  in  1  core inf flag.
- acc_zero  in  1  core zero flag.
- acc_done  in  1  core result valid; asserted ACC_LAT cycles after acc_start.
- m_valid  out  1  batch sum valid.
- m_ready  in  1  consumer accepts the sum.
- m_data  out  NBITS  batch sum posit.
- m_inf  out  1  sum is NaR/inf.
- m_zero  out  1  sum is zero.
- m_count  out  CNT_W  number of terms in the batch, saturating at 2^CNT_W-1.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; acc_in, acc_start, acc_clear, m_valid, m_data, m_inf, m_zero, m_count, busy all 0; timer=0; first=1. Release takes effect on the next rising edge.
- States:
  - IDLE: s_ready=1, first=1. Accept → ISSUE-handling below, then GAP or DRAIN.
  - GAP: s_ready=0; timer counts down. At timer==1, go to ACCEPT, so that s_ready is high in the cycle before spacing expires.
  - ACCEPT: s_ready=1; waiting for the next term.
  - DRAIN: s_ready=0; waiting for the last term's done.
  - OUT: s_ready=0; m_valid=1.
- On accept (s_valid & s_ready) at edge k:
  - During cycle k+1: acc_in=s_data, acc_start=1, acc_clear=first.
  - timer loads ACC_LAT-1; first clears; term counter increments (saturating), restarting at 1 for the first term.
  - Next state is DRAIN if s_last, else GAP.
- acc_start pulses are exactly one cycle. Consecutive pulses are never closer than ACC_LAT cycles. With s_valid held high, throughput is one term per ACC_LAT cycles.
- acc_done is ignored in all states except DRAIN. In DRAIN it is ignored until timer==0; this masks the previous term's done, which coincides with the last acc_start.
- DRAIN, timer==0 and acc_done=1: register m_data=acc_result, m_inf=acc_inf, m_zero=acc_zero, m_count=counter; go to OUT. If acc_done never arrives, the sequencer stays in DRAIN (no timeout).
- OUT:
  - m_valid held with m_data, m_inf, m_zero, m_count stable until m_ready.
  - On m_valid & m_ready: m_valid=0, state goes to IDLE; the next batch can be accepted in the following cycle.
  - m_ready while m_valid=0 has no effect.
- s_valid without s_ready: the term is held by the producer (standard valid/ready). s_data and s_last are sampled only on accept.
- Single-term batch (s_last on the first term): acc_clear=1 with that start, result after ACC_LAT cycles.
- Counter saturates at 2^CNT_W-1; accumulation continues regardless.
- Reset mid-batch: all state is discarded. Any later acc_done from in-flight terms arrives while in IDLE and is ignored. The next batch starts with acc_clear=1.
- Latency, last accept edge to m_valid high: ACC_LAT+1 cycles.

Test Plan:
- Reset asserted mid-GAP with acc_start high → all outputs 0 immediately; IDLE, s_ready=1 after release; a stray acc_done in IDLE leaves m_valid=0.
- Batch {0x40000000, 0x48000000 (last)} (1.0+2.0), s_valid held → acc_start pulses exactly 4 cycles apart, acc_clear=1 only on the first; m_data=0x4C000000, m_count=2, m_valid 5 cycles after the last accept.
- Batch of four 0x40000000 with s_valid gaps of 0–3 random cycles → start spacing ≥4; m_data=0x50000000 (4.0), m_count=4.
- Batch {0x40000000, 0xC0000000 (last)} (1.0−1.0) → m_data=0x00000000, m_zero=1, m_inf=0.
- Single term 0x38000000 with s_last, m_ready held low 10 cycles → m_valid stable with m_data=0x38000000 and s_ready=0 throughout; after m_ready, IDLE next cycle; a back-to-back second batch gets acc_clear=1.
- 300 terms of 0x00000000 → m_count saturates at 255, m_zero=1; no acc_start spacing violations.
